// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int MUL_ITERATIONS = 16;
    localparam int MUL_CNT_W      = 5;

    localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT =
        MUL_CNT_W'(MUL_ITERATIONS - 1);

endpackage

// File: rtl/FullAdder_16bit.sv
// 16-bit ripple-carry adder, organised as four chained 4-bit stages.
module FullAdder_16bit (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] Sum,
    output logic        Cout
);

    logic carry;

    always_comb begin
        carry = Cin;
        Sum   = '0;
        for (int s = 0; s < 4; s++) begin
            for (int b = 0; b < 4; b++) begin
                Sum[4*s+b] = A[4*s+b] ^ B[4*s+b] ^ carry;
                carry      = (A[4*s+b] & B[4*s+b]) |
                             (carry & (A[4*s+b] ^ B[4*s+b]));
            end
        end
        Cout = carry;
    end

endmodule

// File: rtl/shift_add_multiplier_16bit.sv
// Unsigned 16x16->32 multiplier: one add-and-shift step per clock
// through a single 16-bit adder, with a start/busy/done handshake.
module shift_add_multiplier_16bit
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] multiplicand,
    input  logic [15:0] multiplier,
    output logic [31:0] product,
    output logic        busy,
    output logic        done
);

    mul_state_t            state_q, state_d;
    logic [15:0]           a_q, a_d;
    logic [15:0]           q_q, q_d;
    logic [15:0]           m_q, m_d;
    logic [MUL_CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]           product_r_q, product_r_d;

    logic [15:0]           add_b;
    logic [15:0]           add_sum;
    logic                  add_cout;
    logic [31:0]           next_aq;

    assign add_b = q_q[0] ? m_q : 16'h0000;

    FullAdder_16bit u_add (
        .A    (a_q),
        .B    (add_b),
        .Cin  (1'b0),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // Carry-out shifts into A[15], so no bit of the partial sum is lost.
    assign next_aq = {add_cout, add_sum, q_q[15:1]};

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        q_d         = q_q;
        m_d         = m_q;
        cnt_d       = cnt_q;
        product_r_d = product_r_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    m_d     = multiplicand;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = next_aq[31:16];
                q_d   = next_aq[15:0];
                cnt_d = cnt_q + MUL_CNT_W'(1);
                if (cnt_q == MUL_LAST_CNT) begin
                    product_r_d = next_aq;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            q_q         <= '0;
            m_q         <= '0;
            cnt_q       <= '0;
            product_r_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            q_q         <= q_d;
            m_q         <= m_d;
            cnt_q       <= cnt_d;
            product_r_q <= product_r_d;
        end
    end

    assign product = product_r_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shift_add_multiplier_16bit.sv
// Self-checking bench: directed vector table, random operands against
// an arithmetic reference, and hand-written handshake corner cases.
module tb_shift_add_multiplier_16bit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        done;

    int checks;
    int failures;

    shift_add_multiplier_16bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mcand;
        logic [15:0] mplier;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] m,
                                            input logic [15:0] q);
        return 32'(m) * 32'(q);
    endfunction

    // Accept one operation, then verify latency, busy width and result.
    task automatic run_op(input string name, input logic [15:0] m,
                          input logic [15:0] q,
                          input logic [31:0] exp);
        int n;
        int busy_cnt;
        @(negedge clk);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 16'($urandom);
        multiplier   = 16'($urandom);
        chk({name, " busy_after_accept"}, 32'(busy), 32'd1);
        n        = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
        end
        chk({name, " latency"}, 32'(n), 32'd16);
        chk({name, " product"}, product, exp);
        chk({name, " busy_cycles"}, 32'(busy_cnt), 32'd17);
        @(posedge clk);
        #1;
        chk({name, " done_drop"}, {30'd0, busy, done}, 32'd0);
        chk({name, " product_hold"}, product, exp);
    endtask

    initial begin
        int n;
        int d1;
        int d2;
        int ndone;
        logic [31:0] p1;
        logic [31:0] p2;
        logic [15:0] rm;
        logic [15:0] rq;

        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[2] = '{16'h0000, 16'hABCD, 32'h00000000};
        vecs[3] = '{16'h1234, 16'h0000, 32'h00000000};
        vecs[4] = '{16'h8000, 16'h0002, 32'h00010000};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {product[29:0], busy, done}, 32'd0);
        chk("reset_product_hi", {30'd0, product[31:30]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), vecs[i].mcand,
                   vecs[i].mplier, vecs[i].expected);

        for (int i = 0; i < 20; i++) begin
            rm = 16'($urandom);
            rq = 16'($urandom);
            if (i == 0) rm = 16'hFFFF;
            if (i == 1) rq = 16'h0001;
            run_op($sformatf("rand%0d", i), rm, rq, ref_mul(rm, rq));
        end

        // start pulsed during RUN must be ignored
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'h0010;
        multiplier   = 16'h0010;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'hFFFF;
        multiplier   = 16'hFFFF;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        p1    = '0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                p1 = product;
            end
        end
        chk("busy_start ndone", 32'(ndone), 32'd1);
        chk("busy_start product", p1, 32'h00000100);
        chk("busy_start idle", 32'(busy), 32'd0);

        // reset during RUN clears everything with no done pulse
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'h5555;
        multiplier   = 16'h3333;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset outputs", {product[29:0], busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("midreset no_done", 32'(ndone), 32'd0);
        run_op("after_reset", 16'h0007, 16'h0009, 32'h0000003F);

        // start held high: back-to-back operations, 18 cycles apart
        @(negedge clk);
        start        = 1'b1;
        multiplicand = 16'h8000;
        multiplier   = 16'h0002;
        @(posedge clk);
        #1;
        multiplicand = 16'h00FF;
        multiplier   = 16'h0101;
        n  = 0;
        d1 = -1;
        d2 = -1;
        p1 = '0;
        p2 = '0;
        while (d2 < 0 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    p1 = product;
                end else begin
                    d2 = n;
                    p2 = product;
                end
            end
        end
        start = 1'b0;
        chk("b2b first_latency", 32'(d1), 32'd16);
        chk("b2b first_product", p1, 32'h00010000);
        chk("b2b spacing", 32'(d2 - d1), 32'd18);
        chk("b2b second_product", p2, 32'h0000FFFF);
        @(posedge clk);
        #1;
        chk("b2b idle", {30'd0, busy, done}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
